// File: rtl/dp_ctrl_seq.sv
// Control sequencer for the 8-bit shift datapath: load-then-shift-N program,
// paced by a tick prescaler so each control word is held for a whole tick window.
module dp_ctrl_seq #(
   parameter int TICK_DIV = 600,
   parameter int STEP_W   = 4
) (
   input  logic              clk,
   input  logic              clr_n,
   input  logic              start,
   input  logic              abort,
   input  logic              src_sel,
   input  logic [1:0]        mode,
   input  logic [STEP_W-1:0] steps,
   output logic              sel1,
   output logic              sel2,
   output logic [1:0]        func,
   output logic              load,
   output logic              clr,
   output logic              tick,
   output logic              busy,
   output logic              done
);

   localparam int              PW    = $clog2(TICK_DIV);
   localparam logic [PW-1:0]   P_MAX = PW'(TICK_DIV - 1);

   // Control word layout: {busy, done, clr, load, func[1:0], sel2, sel1}
   localparam logic [7:0] CTL_RESET = 8'b0011_0000;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SHIFT,
      S_DONE,
      S_CLR
   } state_t;

   state_t              r_state;
   logic [PW-1:0]       r_presc;
   logic                r_pending;
   logic                r_src;
   logic [1:0]          r_fsel;
   logic [STEP_W-1:0]   r_steps;
   logic [STEP_W-1:0]   r_cnt;
   logic [7:0]          r_ctl;
   logic                w_tick;

   function automatic logic [7:0] ctl_word(input state_t s, input logic src,
                                           input logic [1:0] f);
      logic [7:0] w;
      case (s)
         S_LOAD:  w = {1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, src};
         S_SHIFT: w = {1'b1, 1'b0, 1'b0, 1'b0, f,     1'b1, src};
         S_DONE:  w = {1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, src};
         S_CLR:   w = {1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0};
         default: w = {1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0};
      endcase
      return w;
   endfunction

   assign w_tick = (r_presc == '0);

   always_ff @(posedge clk) begin
      if (!clr_n)
         r_presc <= P_MAX;
      else if (w_tick)
         r_presc <= P_MAX;
      else
         r_presc <= r_presc - PW'(1);
   end

   always_ff @(posedge clk) begin
      if (!clr_n) begin
         r_state   <= S_IDLE;
         r_pending <= 1'b0;
         r_src     <= 1'b0;
         r_fsel    <= 2'b00;
         r_steps   <= '0;
         r_cnt     <= '0;
         r_ctl     <= CTL_RESET;
      end else if (abort) begin
         // abort wins over everything, including a simultaneous start
         r_state   <= S_CLR;
         r_pending <= 1'b0;
         r_ctl     <= ctl_word(S_CLR, r_src, r_fsel);
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_tick && r_pending) begin
                  r_state   <= S_LOAD;
                  r_pending <= 1'b0;
                  r_ctl     <= ctl_word(S_LOAD, r_src, r_fsel);
               end else begin
                  r_ctl <= ctl_word(S_IDLE, r_src, r_fsel);
                  if (start) begin
                     r_pending <= 1'b1;
                     r_src     <= src_sel;
                     r_fsel    <= mode[1] ? 2'b10 : mode;
                     r_steps   <= steps;
                  end
               end
            end
            S_LOAD: begin
               if (w_tick) begin
                  if (r_steps != '0) begin
                     r_state <= S_SHIFT;
                     r_cnt   <= r_steps;
                     r_ctl   <= ctl_word(S_SHIFT, r_src, r_fsel);
                  end else begin
                     r_state <= S_DONE;
                     r_ctl   <= ctl_word(S_DONE, r_src, r_fsel);
                  end
               end
            end
            S_SHIFT: begin
               if (w_tick) begin
                  if (r_cnt == STEP_W'(1)) begin
                     r_state <= S_DONE;
                     r_ctl   <= ctl_word(S_DONE, r_src, r_fsel);
                  end else begin
                     r_cnt <= r_cnt - STEP_W'(1);
                  end
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_ctl   <= ctl_word(S_IDLE, r_src, r_fsel);
            end
            S_CLR: begin
               if (w_tick) begin
                  r_state <= S_IDLE;
                  r_ctl   <= ctl_word(S_IDLE, r_src, r_fsel);
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_ctl   <= ctl_word(S_IDLE, r_src, r_fsel);
            end
         endcase
      end
   end

   assign busy = r_ctl[7];
   assign done = r_ctl[6];
   assign clr  = r_ctl[5];
   assign load = r_ctl[4];
   assign func = r_ctl[3:2];
   assign sel2 = r_ctl[1];
   assign sel1 = r_ctl[0];
   assign tick = w_tick;

endmodule

// File: tb/tb_dp_ctrl_seq.sv
// Directed bench for dp_ctrl_seq: expected control-word windows are queued with
// the stimulus and popped/compared one cycle at a time on the falling edge.
module tb_dp_ctrl_seq;

   localparam int TD = 4;

   logic       clk = 1'b0;
   logic       clr_n = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic       src_sel = 1'b0;
   logic [1:0] mode = 2'b00;
   logic [3:0] steps = 4'd0;
   logic       sel1, sel2, load, clr, tick, busy, done;
   logic [1:0] func;

   int checks = 0;
   int failures = 0;

   // {busy, done, clr, load, func, sel2, sel1}
   localparam logic [7:0] W_RST   = 8'h30;
   localparam logic [7:0] W_IDLE  = 8'h10;
   localparam logic [7:0] W_DONE  = 8'hD0;
   localparam logic [7:0] W_CLR   = 8'hB0;
   localparam logic [7:0] M_ALL   = 8'hFF;
   localparam logic [7:0] M_IDLE  = 8'hFE;
   localparam logic [7:0] M_NOSEL = 8'hFC;

   localparam int A_NONE = 0, A_START = 1, A_ABORT = 2, A_BOTH = 3, A_RST = 4, A_REL = 5;

   typedef struct {
      logic [63:0] tag;
      logic [7:0]  word;
      logic [7:0]  mask;
      int          len;
      bit          tl;
      int          act;
   } exp_t;

   exp_t exp_q[$];

   dp_ctrl_seq #(.TICK_DIV(TD), .STEP_W(4)) dut (
      .clk(clk), .clr_n(clr_n), .start(start), .abort(abort),
      .src_sel(src_sel), .mode(mode), .steps(steps),
      .sel1(sel1), .sel2(sel2), .func(func), .load(load), .clr(clr),
      .tick(tick), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] w_load(input logic s);
      return 8'h80 | {7'b0, s};
   endfunction

   function automatic logic [7:0] w_shift(input logic [1:0] f, input logic s);
      return 8'h82 | {4'b0, f, 2'b00} | {7'b0, s};
   endfunction

   task automatic push(input logic [63:0] tag, input logic [7:0] word, input logic [7:0] mask,
                       input int len, input bit tl, input int act);
      exp_t e;
      e.tag = tag; e.word = word; e.mask = mask; e.len = len; e.tl = tl; e.act = act;
      exp_q.push_back(e);
   endtask

   task automatic sync_tick();
      bit got = 1'b0;
      for (int i = 0; i < 2 * TD && !got; i++) begin
         @(negedge clk);
         if (tick === 1'b1) got = 1'b1;
      end
      checks++;
      assert (got === 1'b1) else begin
         failures++;
         $error("FAIL sync_tick observed=no_tick expected=tick_within_%0d_cycles", 2 * TD);
      end
   endtask

   task automatic run_q();
      exp_t       e;
      logic [7:0] w;
      logic       want_tick;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         for (int c = 0; c < e.len; c++) begin
            @(negedge clk);
            if (start) begin
               // scramble inputs after start: latched values must not follow
               start   = 1'b0;
               src_sel = ~src_sel;
               mode    = ~mode;
               steps   = ~steps;
            end
            abort = 1'b0;
            w = {busy, done, clr, load, func, sel2, sel1};
            checks++;
            assert ((w & e.mask) === (e.word & e.mask)) else begin
               failures++;
               $error("FAIL %s cyc%0d ctl observed=%h expected=%h", e.tag, c, w & e.mask, e.word & e.mask);
            end
            want_tick = (e.tl && c == e.len - 1);
            checks++;
            assert (tick === want_tick) else begin
               failures++;
               $error("FAIL %s cyc%0d tick observed=%b expected=%b", e.tag, c, tick, want_tick);
            end
            if (c == e.len - 1) begin
               case (e.act)
                  A_START: start = 1'b1;
                  A_ABORT: abort = 1'b1;
                  A_BOTH:  begin start = 1'b1; abort = 1'b1; end
                  A_RST:   clr_n = 1'b0;
                  A_REL:   clr_n = 1'b1;
                  default: ;
               endcase
            end
         end
      end
   endtask

   // Aligns to a tick, then queues the start cycle and the wait to the next tick.
   task automatic prog_head(input logic s, input logic [1:0] m, input logic [3:0] n);
      src_sel = s; mode = m; steps = n;
      sync_tick();
      push("idl_pre", W_IDLE, M_IDLE, 1, 1'b0, A_START);
      push("idl_pend", W_IDLE, M_IDLE, 3, 1'b1, A_NONE);
   endtask

   initial begin
      // reset held 3 cycles, then free-running ticks
      push("reset", W_RST, M_ALL, 3, 1'b0, A_REL);
      push("idle_a", W_IDLE, M_IDLE, 3, 1'b1, A_NONE);
      push("idle_b", W_IDLE, M_IDLE, TD, 1'b1, A_NONE);
      push("idle_c", W_IDLE, M_IDLE, TD, 1'b1, A_NONE);
      run_q();

      // src b, shift right, 3 steps
      prog_head(1'b1, 2'b01, 4'd3);
      push("p1_load", w_load(1'b1), M_ALL, TD, 1'b1, A_NONE);
      for (int k = 0; k < 3; k++) push("p1_shift", w_shift(2'b01, 1'b1), M_ALL, TD, 1'b1, A_NONE);
      push("p1_done", W_DONE, M_NOSEL, 1, 1'b0, A_NONE);
      push("p1_idle", W_IDLE, M_IDLE, 1, 1'b0, A_NONE);
      run_q();

      // zero steps: no shift window at all
      prog_head(1'b0, 2'b10, 4'd0);
      push("p2_load", w_load(1'b0), M_ALL, TD, 1'b1, A_NONE);
      push("p2_done", W_DONE, M_NOSEL, 1, 1'b0, A_NONE);
      push("p2_idle", W_IDLE, M_IDLE, 1, 1'b0, A_NONE);
      run_q();

      // mode 11 maps to left shift
      prog_head(1'b0, 2'b11, 4'd2);
      push("p3_load", w_load(1'b0), M_ALL, TD, 1'b1, A_NONE);
      for (int k = 0; k < 2; k++) push("p3_shift", w_shift(2'b10, 1'b0), M_ALL, TD, 1'b1, A_NONE);
      push("p3_done", W_DONE, M_NOSEL, 1, 1'b0, A_NONE);
      push("p3_idle", W_IDLE, M_IDLE, 1, 1'b0, A_NONE);
      run_q();

      // abort in the 2nd of 5 shift windows
      prog_head(1'b0, 2'b01, 4'd5);
      push("p4_load", w_load(1'b0), M_ALL, TD, 1'b1, A_NONE);
      push("p4_sh1", w_shift(2'b01, 1'b0), M_ALL, TD, 1'b1, A_NONE);
      push("p4_sh2", w_shift(2'b01, 1'b0), M_ALL, 1, 1'b0, A_ABORT);
      push("p4_clr", W_CLR, M_NOSEL, 3, 1'b1, A_NONE);
      push("p4_idle", W_IDLE, M_IDLE, TD, 1'b1, A_NONE);
      run_q();

      // new program accepted after the abort
      prog_head(1'b1, 2'b10, 4'd1);
      push("p5_load", w_load(1'b1), M_ALL, TD, 1'b1, A_NONE);
      push("p5_shift", w_shift(2'b10, 1'b1), M_ALL, TD, 1'b1, A_NONE);
      push("p5_done", W_DONE, M_NOSEL, 1, 1'b0, A_NONE);
      push("p5_idle", W_IDLE, M_IDLE, 1, 1'b0, A_NONE);
      run_q();

      // start during SHIFT is ignored, not queued
      prog_head(1'b1, 2'b10, 4'd3);
      push("p6_load", w_load(1'b1), M_ALL, TD, 1'b1, A_NONE);
      push("p6_sh1a", w_shift(2'b10, 1'b1), M_ALL, 1, 1'b0, A_START);
      push("p6_sh1b", w_shift(2'b10, 1'b1), M_ALL, 3, 1'b1, A_NONE);
      for (int k = 0; k < 2; k++) push("p6_shift", w_shift(2'b10, 1'b1), M_ALL, TD, 1'b1, A_NONE);
      push("p6_done", W_DONE, M_NOSEL, 1, 1'b0, A_NONE);
      push("p6_idl1", W_IDLE, M_IDLE, 1, 1'b0, A_NONE);
      push("p6_idl2", W_IDLE, M_IDLE, 2, 1'b1, A_NONE);
      push("p6_idl3", W_IDLE, M_IDLE, TD, 1'b1, A_NONE);
      push("p6_idl4", W_IDLE, M_IDLE, 1, 1'b0, A_NONE);
      run_q();

      // start and abort together in IDLE: CLR, never LOAD
      sync_tick();
      push("p7_both", W_IDLE, M_IDLE, 1, 1'b0, A_BOTH);
      push("p7_clr", W_CLR, M_NOSEL, 3, 1'b1, A_NONE);
      push("p7_idl1", W_IDLE, M_IDLE, TD, 1'b1, A_NONE);
      push("p7_idl2", W_IDLE, M_IDLE, TD, 1'b1, A_NONE);
      run_q();

      // reset mid-LOAD
      prog_head(1'b1, 2'b01, 4'd2);
      push("p8_load", w_load(1'b1), M_ALL, 2, 1'b0, A_RST);
      push("p8_rst", W_RST, M_ALL, 2, 1'b0, A_REL);
      push("p8_idl1", W_IDLE, M_IDLE, 3, 1'b1, A_NONE);
      push("p8_idl2", W_IDLE, M_IDLE, TD, 1'b1, A_NONE);
      run_q();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
